color_channel_router: RTL and testbench
=======================================

Name: color_channel_router

Overview:
- Streaming, parametrised successor to the fixed 3x8-bit color channel scrambler.
- Routes NCH input channels of CW bits to NCH output channels through a per-output source select. A select value of NCH or above forces zero.
- Sits in the pixel path between the frame source and the display/encoder stage.
- Adds a valid/ready handshake, a 2-stage pipeline and frame-synchronous configuration update, so a mapping change never tears a frame.

Parameters:
- NCH, 3, number of color channels per pixel.
- CW, 8, bits per channel.
- SW, $clog2(NCH+1), select width per output channel (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cfg_sel  in  NCH*SW  requested mapping; output channel i select at [(NCH-i)*SW-1 -: SW]
- cfg_load  in  1  strobe: capture cfg_sel into shadow register
- cfg_pending  out  1  shadow captured, not yet applied
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  NCH*CW  pixel; channel 0 in MSBs, channel i at [(NCH-i)*CW-1 -: CW]
- s_sof  in  1  first pixel of frame
- s_eof  in  1  last pixel of frame
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_data  out  NCH*CW  routed pixel, same packing as s_data
- m_sof  out  1  s_sof delayed with its beat
- m_eof  out  1  s_eof delayed with its beat

Behaviour:
- Reset values:
  - m_valid=0, m_data=0, m_sof=0, m_eof=0, cfg_pending=0, both stage valids=0.
  - Active mapping = identity (output i selects input i); shadow = identity; in_frame=0.
- Routing: output channel i = s_data channel active_sel[i] if active_sel[i] < NCH, else all-zero CW bits. The mux is evaluated in stage 1 with the mapping in force when the beat is accepted.
- Pipeline:
  - Two register stages; latency is exactly 2 cycles from acceptance to m_valid with m_ready held high.
  - Throughput is 1 beat/cycle.
  - Each stage loads when it is empty or its contents are being taken the same cycle. s_ready = stage-1 load condition.
  - m_data, m_sof and m_eof are stable while m_valid && !m_ready. No beat is dropped or duplicated.
- Frame tracking: in_frame is set on an accepted beat with s_sof && !s_eof and cleared on an accepted beat with s_eof. A single-beat frame (sof && eof) leaves in_frame=0.
- Configuration state machine (IDLE, PENDING):
  - IDLE: cfg_load captures cfg_sel into the shadow.
    - If in_frame=0 and no sof beat is accepted that cycle, active <= cfg_sel at the next edge and the machine stays IDLE.
    - Otherwise go to PENDING with cfg_pending=1.
  - PENDING: on the first accepted beat with s_sof, that beat uses the shadow mapping, active <= shadow, and the machine returns to IDLE.
    - In PENDING, if an accepted eof beat makes in_frame=0 with no sof the same cycle, the shadow is applied at the next edge.
  - cfg_load in the same cycle as an accepted sof beat: cfg_sel applies directly to that beat, and active <= cfg_sel.
  - A second cfg_load while PENDING overwrites the shadow (last write wins).
- Reset mid-frame or mid-pipeline: all in-flight beats are discarded, and state returns to the reset values above.
- Select values NCH..2^SW-1 all map to zero; no error is flagged.

Optional Feature:
- Macro: COLOR_ROUTER_INVERT_EN
- Defined:
  - Adds port cfg_inv (in, NCH bits), captured and applied alongside cfg_sel by the same shadow/active rules.
  - Output channel i is bitwise inverted after selection when the active inv[i]=1. This includes zero-selected channels, which therefore output all-ones.
  - Reset inv = 0.
- Undefined: the port is absent and no inversion logic exists.

Decomposition:
- Package color_stream_pkg holds:
  - default NCH/CW localparams;
  - function sel_width(nch);
  - function identity_map(nch), returning a packed identity select vector;
  - typedef enum {CFG_IDLE, CFG_PENDING} cfg_state_t.
- Sub-module stream_pipe_stage: one valid/ready register slice, parametrised by payload width, instantiated twice. The routing mux stays inline in the top.

Test Plan:
- Identity after reset:
  - Stimulus: reset, then feed s_data=0x112233 with m_ready=1.
  - Required: m_data=0x112233 exactly 2 cycles after acceptance, and cfg_pending=0.
- Idle reconfiguration:
  - Stimulus: while idle, cfg_load with map {2,0,3}, then feed 0xAABBCC.
  - Required: m_data=0xCCAA00.
- Mid-frame deferral:
  - Stimulus: after an accepted sof beat, cfg_load with map {1,1,1}, then send the rest of the frame.
  - Required: remaining beats keep the old mapping and cfg_pending=1. The next sof beat 0x102030 yields 0x202020, after which cfg_pending=0.
- Backpressure:
  - Stimulus: hold m_ready=0 for 5 cycles with continuous s_valid.
  - Required: s_ready drops after 2 beats are buffered and m_data holds. After release the beats emerge in order with none lost or duplicated, including m_sof/m_eof alignment.
- Same-cycle load and sof:
  - Stimulus: cfg_load with map {0,2,1} in the same cycle as an accepted sof beat 0x010203.
  - Required: m_data=0x010302.
- Reset mid-frame (and, with COLOR_ROUTER_INVERT_EN, inversion):
  - Reset stimulus: assert rst with beats in flight and PENDING set.
  - Reset required: m_valid=0 immediately, identity restored, and cfg_pending=0.
  - Inversion stimulus (COLOR_ROUTER_INVERT_EN defined): identity map, inv=3'b100, input 0x112233.
  - Inversion required: m_data=0xEE2233.

Source files
------------

// File: rtl/color_stream_pkg.sv
// rtl/color_stream_pkg.sv - shared types, defaults and helpers for the color channel router
//
// Contents:
//   DEFAULT_NCH / DEFAULT_CW : default channel count and channel width
//   MAP_MAX_W                : width of the vector returned by identity_map
//   sel_width(nch)           : bits needed per output select (values 0..nch, nch = force zero)
//   identity_map(nch)        : packed select vector with output i selecting input i,
//                              output 0 in the most significant field
//   cfg_state_t              : mapping update state (CFG_IDLE, CFG_PENDING)
package color_stream_pkg;

  localparam int DEFAULT_NCH = 3;
  localparam int DEFAULT_CW  = 8;
  localparam int MAP_MAX_W   = 64;

  function automatic int sel_width(input int nch);
    return $clog2(nch + 1);
  endfunction

  // Field i occupies bits [(nch-i)*sw-1 -: sw]; the result is right-aligned in
  // MAP_MAX_W bits so callers take the low nch*sw bits.
  function automatic logic [MAP_MAX_W-1:0] identity_map(input int nch);
    logic [MAP_MAX_W-1:0] m;
    int sw;
    m  = '0;
    sw = sel_width(nch);
    for (int i = 0; i < nch; i++) begin
      for (int b = 0; b < sw; b++) begin
        if ((nch - 1 - i) * sw + b < MAP_MAX_W) begin
          m[(nch - 1 - i) * sw + b] = i[b];
        end
      end
    end
    return m;
  endfunction

  typedef enum logic [0:0] {
    CFG_IDLE,
    CFG_PENDING
  } cfg_state_t;

endpackage

// File: rtl/stream_pipe_stage.sv
// rtl/stream_pipe_stage.sv - one valid/ready register slice with a registered payload
//
// Parameters:
//   W        payload width
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset; clears valid and payload
//   s_valid  upstream beat valid
//   s_ready  slice can take a beat (empty, or its content leaves this cycle)
//   s_data   upstream payload
//   m_valid  slice holds a beat
//   m_ready  downstream takes the held beat
//   m_data   held payload, stable while m_valid && !m_ready
module stream_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  assign s_ready = !m_valid || m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (s_ready) begin
      m_valid <= s_valid;
      // Payload only moves with a real beat so m_data keeps the last value when idle.
      if (s_valid) begin
        m_data <= s_data;
      end
    end
  end

endmodule

// File: rtl/color_channel_router.sv
// rtl/color_channel_router.sv - per-output color channel select with frame-synchronous remapping
//
// Optional feature macro: COLOR_ROUTER_INVERT_EN (adds cfg_inv and per-output inversion).
//
// Parameters:
//   NCH   color channels per pixel
//   CW    bits per channel
//   SW    select width per output (derived, leave at default)
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   cfg_sel      requested mapping, output i select at [(NCH-i)*SW-1 -: SW]; >= NCH forces zero
//   cfg_inv      (COLOR_ROUTER_INVERT_EN only) per-output invert, output i at bit NCH-1-i
//   cfg_load     capture cfg_sel (and cfg_inv) into the shadow register
//   cfg_pending  shadow captured but waiting for a frame boundary
//   s_valid/s_ready/s_data/s_sof/s_eof  input pixel stream, channel 0 in the MSBs
//   m_valid/m_ready/m_data/m_sof/m_eof  routed pixel stream, same packing, 2-cycle latency
module color_channel_router
  import color_stream_pkg::*;
#(
  parameter int NCH = DEFAULT_NCH,
  parameter int CW  = DEFAULT_CW,
  parameter int SW  = sel_width(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*SW-1:0] cfg_sel,
`ifdef COLOR_ROUTER_INVERT_EN
  input  logic [NCH-1:0]    cfg_inv,
`endif
  input  logic              cfg_load,
  output logic              cfg_pending,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [NCH*CW-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_eof,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [NCH*CW-1:0] m_data,
  output logic              m_sof,
  output logic              m_eof
);

  localparam int DW = NCH * CW;
  localparam int PW = DW + 2;
  localparam logic [MAP_MAX_W-1:0] ID_FULL = identity_map(NCH);
  localparam logic [NCH*SW-1:0]    ID_MAP  = ID_FULL[NCH*SW-1:0];

  cfg_state_t        cfg_state;
  logic              in_frame;
  logic [NCH*SW-1:0] active_sel;
  logic [NCH*SW-1:0] shadow_sel;
  logic [NCH*SW-1:0] next_shadow_sel;
  logic [NCH*SW-1:0] beat_sel;
  logic              accept;
  logic              acc_sof;
  logic              acc_eof;
  logic              sof_takes_shadow;
  logic [DW-1:0]     routed;
  logic [CW-1:0]     ch;
  logic              st1_valid;
  logic              st1_ready;
  logic [PW-1:0]     st1_data;
  logic [PW-1:0]     st2_data;

`ifdef COLOR_ROUTER_INVERT_EN
  logic [NCH-1:0]    active_inv;
  logic [NCH-1:0]    shadow_inv;
  logic [NCH-1:0]    next_shadow_inv;
  logic [NCH-1:0]    beat_inv;
`endif

  assign accept  = s_valid && s_ready;
  assign acc_sof = accept && s_sof;
  assign acc_eof = accept && s_eof;

  // The freshest requested mapping: this cycle's cfg_sel wins over the stored shadow.
  assign next_shadow_sel = cfg_load ? cfg_sel : shadow_sel;

  // A sof beat adopts a waiting (or same-cycle) mapping itself. Gated on s_valid
  // rather than acceptance: the mux result only matters for an accepted beat,
  // and this keeps m_ready out of the select path.
  assign sof_takes_shadow = s_valid && s_sof && (cfg_load || (cfg_state == CFG_PENDING));
  assign beat_sel         = sof_takes_shadow ? next_shadow_sel : active_sel;

`ifdef COLOR_ROUTER_INVERT_EN
  assign next_shadow_inv = cfg_load ? cfg_inv : shadow_inv;
  assign beat_inv        = sof_takes_shadow ? next_shadow_inv : active_inv;
`endif

  always_comb begin
    routed = '0;
    ch     = '0;
    for (int i = 0; i < NCH; i++) begin
      ch = '0;
      // Select values NCH and above match no input and leave the channel at zero.
      for (int j = 0; j < NCH; j++) begin
        if (int'(beat_sel[(NCH-i)*SW-1 -: SW]) == j) begin
          ch = s_data[(NCH-j)*CW-1 -: CW];
        end
      end
`ifdef COLOR_ROUTER_INVERT_EN
      if (beat_inv[NCH-1-i]) begin
        ch = ~ch;
      end
`endif
      routed[(NCH-i)*CW-1 -: CW] = ch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_state   <= CFG_IDLE;
      cfg_pending <= 1'b0;
      in_frame    <= 1'b0;
      active_sel  <= ID_MAP;
      shadow_sel  <= ID_MAP;
`ifdef COLOR_ROUTER_INVERT_EN
      active_inv  <= '0;
      shadow_inv  <= '0;
`endif
    end else begin
      if (accept) begin
        in_frame <= s_eof ? 1'b0 : (s_sof ? 1'b1 : in_frame);
      end
      if (cfg_load) begin
        shadow_sel <= cfg_sel;
`ifdef COLOR_ROUTER_INVERT_EN
        shadow_inv <= cfg_inv;
`endif
      end
      case (cfg_state)
        CFG_IDLE: begin
          if (cfg_load) begin
            // Safe to switch now between frames, or when the new frame starts this cycle.
            if (acc_sof || !in_frame) begin
              active_sel <= cfg_sel;
`ifdef COLOR_ROUTER_INVERT_EN
              active_inv <= cfg_inv;
`endif
            end else begin
              cfg_state   <= CFG_PENDING;
              cfg_pending <= 1'b1;
            end
          end
        end
        CFG_PENDING: begin
          // Apply at the next frame boundary: the new frame's sof or the old frame's eof.
          if (acc_sof || acc_eof) begin
            active_sel  <= next_shadow_sel;
`ifdef COLOR_ROUTER_INVERT_EN
            active_inv  <= next_shadow_inv;
`endif
            cfg_state   <= CFG_IDLE;
            cfg_pending <= 1'b0;
          end
        end
        default: begin
          cfg_state   <= CFG_IDLE;
          cfg_pending <= 1'b0;
        end
      endcase
    end
  end

  stream_pipe_stage #(.W(PW)) u_stage1 (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  ({routed, s_sof, s_eof}),
    .m_valid (st1_valid),
    .m_ready (st1_ready),
    .m_data  (st1_data)
  );

  stream_pipe_stage #(.W(PW)) u_stage2 (
    .clk     (clk),
    .rst     (rst),
    .s_valid (st1_valid),
    .s_ready (st1_ready),
    .s_data  (st1_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (st2_data)
  );

  assign m_data = st2_data[PW-1:2];
  assign m_sof  = st2_data[1];
  assign m_eof  = st2_data[0];

endmodule

// File: tb/tb_color_channel_router.sv
// tb/tb_color_channel_router.sv - self-checking bench for color_channel_router
module tb_color_channel_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  cfg_sel;
  logic        cfg_load;
  logic        cfg_pending;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_sof;
  logic        s_eof;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic        m_sof;
  logic        m_eof;
`ifdef COLOR_ROUTER_INVERT_EN
  logic [2:0]  cfg_inv_b;
`endif

  color_channel_router dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_sel     (cfg_sel),
`ifdef COLOR_ROUTER_INVERT_EN
    .cfg_inv     (cfg_inv_b),
`endif
    .cfg_load    (cfg_load),
    .cfg_pending (cfg_pending),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .s_eof       (s_eof),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_sof       (m_sof),
    .m_eof       (m_eof)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] pack3(input int a, input int b, input int c);
    logic [1:0] fa, fb, fc;
    fa = a[1:0];
    fb = b[1:0];
    fc = c[1:0];
    return {fa, fb, fc};
  endfunction

  // Reference routing: output i takes input channel sel[i], zero if out of range.
  function automatic logic [23:0] route(input logic [23:0] d, input logic [5:0] sel, input logic [2:0] inv);
    logic [23:0] r;
    logic [7:0]  c;
    int s;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      s = int'(sel[(2-i)*2 +: 2]);
      c = 8'h00;
      if (s < 3) c = d[(2-s)*8 +: 8];
      if (inv[2-i]) c = ~c;
      r[(2-i)*8 +: 8] = c;
    end
    return r;
  endfunction

  // Behavioural model: mapping state and expected output order.
  logic [5:0]  md_act, md_shd, md_sel;
  logic [2:0]  md_iact, md_ishd, md_inv, inv_in;
  bit          md_pend, md_inf, prev_stall, acc;
  logic [25:0] exp_q[$];
  logic [25:0] prev_out, e;

  always @(negedge clk) begin
    if (rst) begin
      md_act = pack3(0, 1, 2); md_shd = pack3(0, 1, 2);
      md_iact = 3'b000; md_ishd = 3'b000;
      md_pend = 0; md_inf = 0; prev_stall = 0;
      exp_q.delete();
    end else begin
      check("cfg_pending", 64'(cfg_pending), 64'(md_pend));
      if (prev_stall) check("stall_hold", 64'({m_valid, m_sof, m_eof, m_data}), 64'({1'b1, prev_out}));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'(m_valid), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("beat", 64'({m_sof, m_eof, m_data}), 64'(e));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_sof, m_eof, m_data};
`ifdef COLOR_ROUTER_INVERT_EN
      inv_in = cfg_inv_b;
`else
      inv_in = 3'b000;
`endif
      acc    = s_valid && s_ready;
      md_sel = md_act;
      md_inv = md_iact;
      if (acc && s_sof && cfg_load) begin md_sel = cfg_sel; md_inv = inv_in; end
      else if (acc && s_sof && md_pend) begin md_sel = md_shd; md_inv = md_ishd; end
      if (acc) exp_q.push_back({s_sof, s_eof, route(s_data, md_sel, md_inv)});
      if (cfg_load) begin md_shd = cfg_sel; md_ishd = inv_in; end
      if (acc && s_sof) begin
        if (cfg_load || md_pend) begin md_act = md_shd; md_iact = md_ishd; end
        md_pend = 0;
      end else if (md_pend && acc && s_eof) begin
        md_act = md_shd; md_iact = md_ishd; md_pend = 0;
      end else if (cfg_load && !md_pend) begin
        if (!md_inf) begin md_act = cfg_sel; md_iact = inv_in; end
        else md_pend = 1;
      end
      if (acc) md_inf = s_eof ? 1'b0 : (s_sof ? 1'b1 : md_inf);
    end
  end

  task automatic send(input logic [23:0] d, input logic sof, input logic eof,
                      input logic load, input logic [5:0] sel, output int acc_c);
    int k;
    @(posedge clk); #1;
    s_valid = 1; s_data = d; s_sof = sof; s_eof = eof; cfg_load = load; cfg_sel = sel;
    k = 0;
    @(negedge clk);
    while (!s_ready && k < 20) begin @(negedge clk); k++; end
    if (!s_ready) check("accept_timeout", 64'(s_ready), 64'(1));
    acc_c = cyc;
    @(posedge clk); #1;
    s_valid = 0; s_sof = 0; s_eof = 0; cfg_load = 0;
  endtask

  task automatic load_only(input logic [5:0] sel);
    @(posedge clk); #1;
    cfg_load = 1; cfg_sel = sel;
    @(posedge clk); #1;
    cfg_load = 0;
  endtask

  task automatic expect_lit(input string name, input logic [23:0] exp, input int acc_c);
    int k;
    k = 0;
    @(negedge clk);
    while (!m_valid && k < 10) begin @(negedge clk); k++; end
    check({name, "_latency"}, 64'(cyc - acc_c), 64'(2));
    check(name, 64'(m_data), 64'(exp));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  logic [23:0] bp[6];
  int ac, w;

  initial begin
    rst = 1; cfg_sel = pack3(0, 1, 2); cfg_load = 0; s_valid = 0; s_data = 0;
    s_sof = 0; s_eof = 0; m_ready = 1;
`ifdef COLOR_ROUTER_INVERT_EN
    cfg_inv_b = 3'b000;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    check("rst_sof_eof", 64'({m_sof, m_eof}), 64'(0));
    check("rst_cfg_pending", 64'(cfg_pending), 64'(0));
    rst = 0;
    #1 check("idle_s_ready", 64'(s_ready), 64'(1));

    // Identity after reset
    send(24'h112233, 1, 1, 0, pack3(0, 1, 2), ac);
    expect_lit("identity", 24'h112233, ac);
    check("identity_pending", 64'(cfg_pending), 64'(0));

    // Idle reconfiguration, including a zero-selected output
    load_only(pack3(2, 0, 3));
    @(negedge clk) check("idle_load_pending", 64'(cfg_pending), 64'(0));
    send(24'hAABBCC, 1, 1, 0, pack3(2, 0, 3), ac);
    expect_lit("idle_remap", 24'hCCAA00, ac);

    // Mid-frame deferral
    send(24'h010203, 1, 0, 0, pack3(2, 0, 3), ac);
    expect_lit("frame_first", 24'h030100, ac);
    load_only(pack3(1, 1, 1));
    @(negedge clk) check("defer_pending", 64'(cfg_pending), 64'(1));
    send(24'h445566, 0, 0, 0, pack3(1, 1, 1), ac);
    expect_lit("frame_mid_old_map", 24'h664400, ac);
    check("defer_pending_mid", 64'(cfg_pending), 64'(1));
    send(24'h778899, 0, 1, 0, pack3(1, 1, 1), ac);
    expect_lit("frame_last_old_map", 24'h997700, ac);
    send(24'h102030, 1, 1, 0, pack3(1, 1, 1), ac);
    expect_lit("next_frame_new_map", 24'h202020, ac);
    check("applied_pending", 64'(cfg_pending), 64'(0));

    // Same-cycle load and sof
    send(24'h010203, 1, 1, 1, pack3(0, 2, 1), ac);
    expect_lit("same_cycle_load", 24'h010302, ac);
    check("same_cycle_pending", 64'(cfg_pending), 64'(0));

    // Backpressure: m_ready low for 5 cycles with continuous input
    for (int k = 0; k < 6; k++) bp[k] = 24'h0A0B0C + 24'(k) * 24'h010101;
    @(posedge clk); #1;
    m_ready = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          s_valid = 1; s_data = bp[k]; s_sof = (k == 0); s_eof = (k == 5);
          w = 0;
          @(negedge clk);
          while (!s_ready && w < 30) begin @(negedge clk); w++; end
          if (!s_ready) check("bp_accept_timeout", 64'(s_ready), 64'(1));
          @(posedge clk); #1;
        end
        s_valid = 0; s_sof = 0; s_eof = 0;
      end
      begin
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("bp_s_ready_low", 64'(s_ready), 64'(0));
        check("bp_m_valid", 64'(m_valid), 64'(1));
        check("bp_head", 64'({m_sof, m_data}), 64'({1'b1, 24'h0A0C0B}));
        repeat (3) @(posedge clk);
        #1 m_ready = 1;
      end
    join
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin @(negedge clk); w++; end
    check("bp_drain", 64'(exp_q.size()), 64'(0));

    // Reset with beats in flight and a pending mapping
    send(24'h0000FF, 1, 0, 0, pack3(0, 2, 1), ac);
    load_only(pack3(2, 1, 0));
    @(negedge clk) check("pre_rst_pending", 64'(cfg_pending), 64'(1));
    @(posedge clk); #1 m_ready = 0;
    send(24'h123456, 0, 0, 0, pack3(2, 1, 0), ac);
    send(24'h654321, 0, 0, 0, pack3(2, 1, 0), ac);
    rst = 1;
    #1;
    check("rst_async_m_valid", 64'(m_valid), 64'(0));
    check("rst_async_pending", 64'(cfg_pending), 64'(0));
    check("rst_async_m_data", 64'(m_data), 64'(0));
    @(posedge clk); #1;
    rst = 0; m_ready = 1;
    send(24'h112233, 1, 1, 0, pack3(2, 1, 0), ac);
    expect_lit("post_rst_identity", 24'h112233, ac);

`ifdef COLOR_ROUTER_INVERT_EN
    cfg_inv_b = 3'b100;
    send(24'h112233, 1, 1, 1, pack3(0, 1, 2), ac);
    expect_lit("invert_ch0", 24'hEE2233, ac);
    cfg_inv_b = 3'b001;
    send(24'h112233, 1, 1, 1, pack3(0, 1, 3), ac);
    expect_lit("invert_zero_sel", 24'h1122FF, ac);
`endif

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
